// File: rtl/l2_pkg.sv
// Shared constants and types for the L2 stream fill path.
//   L2_NCL       : cache-line slots per stream (power of 2)
//   L2_NCL_WIDTH : slot index width
//   CL_WIDTH     : cache-line width in bits
package l2_pkg;

  localparam int unsigned L2_NCL       = 256;
  localparam int unsigned L2_NCL_WIDTH = $clog2(L2_NCL);
  localparam int unsigned CL_WIDTH     = 512;

  typedef logic [L2_NCL_WIDTH-1:0] l2_slot_t;
  typedef logic [L2_NCL_WIDTH:0]   l2_cnt_t;
  typedef logic [CL_WIDTH-1:0]     cl_t;

  // Payload held in the URAM write stage
  typedef struct packed {
    l2_slot_t addr;
    cl_t      data;
  } l2_wr_t;

endpackage

// File: rtl/l2_fill_done_map.sv
// Per-slot "line written, awaiting retire" bitmap.
//   set_en/set_idx : mark slot written (wins over clear on the same slot)
//   clr_en/clr_idx : clear slot on retire
//   flush          : clear every slot (stream clear)
//   rd_idx/rd_bit_c: combinational read of the registered bitmap
// Macro L2_STREAM_FILL_CHECK_EN adds a second read port (chk_idx/chk_bit_c).
module l2_fill_done_map
  import l2_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  l2_slot_t set_idx,
  input  logic     clr_en,
  input  l2_slot_t clr_idx,
  input  logic     flush,
  input  l2_slot_t rd_idx,
  output logic     rd_bit_c
`ifdef L2_STREAM_FILL_CHECK_EN
  ,
  input  l2_slot_t chk_idx,
  output logic     chk_bit_c
`endif
);

  logic [L2_NCL-1:0] done_q;
  logic [L2_NCL-1:0] done_d;

  // Next bitmap: clear applied first so a set on the same slot wins
  always_comb begin
    done_d = done_q;
    if (flush) begin
      done_d = '0;
    end else begin
      if (clr_en) done_d[clr_idx] = 1'b0;
      if (set_en) done_d[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= '0;
    else        done_q <= done_d;
  end

  assign rd_bit_c = done_q[rd_idx];

`ifdef L2_STREAM_FILL_CHECK_EN
  assign chk_bit_c = done_q[chk_idx];
`endif

endmodule

// File: rtl/l2_stream_fill.sv
// L2 stream fill: tags outgoing requests with an L2 slot, writes (possibly
// out-of-order) responses into URAM through one register stage, and retires
// completions to the stream pointer strictly in issue order.
//   i_req_*  / o_req_*  : request in from stream pointer, tagged request out
//   i_rsp_*             : OpenCAPI response (tag + cache line)
//   o_wr_*              : URAM write port
//   o_rsp_v / o_rsp_r   : in-order completion to stream pointer
//   i_clr_v / i_clr_r   : stream clear, accepted only when fully drained
//   o_cnt               : allocated but not yet retired slots
// Macro L2_STREAM_FILL_CHECK_EN adds sticky o_err for illegal response tags;
// such responses are consumed but not written.
module l2_stream_fill
  import l2_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_v,
  output logic                  i_req_r,
  output logic                  o_req_v,
  input  logic                  o_req_r,
  output l2_slot_t              o_req_tag,
  input  logic                  i_rsp_v,
  output logic                  i_rsp_r,
  input  l2_slot_t              i_rsp_tag,
  input  cl_t                   i_rsp_d,
  output logic                  o_wr_v,
  input  logic                  o_wr_r,
  output l2_slot_t              o_wr_addr,
  output cl_t                   o_wr_d,
  output logic                  o_rsp_v,
  input  logic                  o_rsp_r,
  input  logic                  i_clr_v,
  output logic                  i_clr_r,
  output logic [L2_NCL_WIDTH:0] o_cnt
`ifdef L2_STREAM_FILL_CHECK_EN
  ,
  output logic                  o_err
`endif
);

  localparam l2_cnt_t CNT_FULL = l2_cnt_t'(L2_NCL);

  l2_slot_t alloc_ptr;
  l2_slot_t retire_ptr;
  l2_cnt_t  cnt_q;
  logic     wr_v_q;
  l2_wr_t   wr_q;

  logic full;
  logic req_hs;
  logic rsp_hs;
  logic wr_hs;
  logic ret_hs;
  logic clr_hs;
  logic wr_load;
  logic head_done;

  // Handshakes; a pending clear blocks allocation in the same cycle
  assign full    = (cnt_q == CNT_FULL);
  assign i_req_r = o_req_r & ~full & ~i_clr_v;
  assign o_req_v = i_req_v & ~full & ~i_clr_v;
  assign req_hs  = i_req_v & i_req_r;
  assign o_req_tag = alloc_ptr;

  assign i_rsp_r = ~wr_v_q | o_wr_r;
  assign rsp_hs  = i_rsp_v & i_rsp_r;
  assign wr_hs   = wr_v_q & o_wr_r;

  assign o_rsp_v = head_done;
  assign ret_hs  = head_done & o_rsp_r;

  assign i_clr_r = (cnt_q == '0) & ~wr_v_q;
  assign clr_hs  = i_clr_v & i_clr_r;

  assign o_wr_v    = wr_v_q;
  assign o_wr_addr = wr_q.addr;
  assign o_wr_d    = wr_q.data;
  assign o_cnt     = cnt_q;

`ifdef L2_STREAM_FILL_CHECK_EN
  // A legal tag lies in [retire_ptr, retire_ptr+cnt) and is neither done
  // nor sitting in the write stage
  l2_slot_t rsp_off;
  logic     in_win;
  logic     chk_done;
  logic     rsp_bad;
  logic     err_q;

  assign rsp_off = i_rsp_tag - retire_ptr;
  assign in_win  = l2_cnt_t'(rsp_off) < cnt_q;
  assign rsp_bad = ~in_win | chk_done | (wr_v_q & (wr_q.addr == i_rsp_tag));
  assign wr_load = rsp_hs & ~rsp_bad;
  assign o_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                err_q <= 1'b0;
    else if (clr_hs)           err_q <= 1'b0;
    else if (rsp_hs & rsp_bad) err_q <= 1'b1;
  end
`else
  assign wr_load = rsp_hs;
`endif

  // URAM write stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_v_q <= 1'b0;
      wr_q   <= '0;
    end else if (wr_load) begin
      wr_v_q    <= 1'b1;
      wr_q.addr <= i_rsp_tag;
      wr_q.data <= i_rsp_d;
    end else if (wr_hs) begin
      wr_v_q <= 1'b0;
    end
  end

  // Slot pointers, reset to zero by a stream clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_ptr  <= '0;
      retire_ptr <= '0;
    end else if (clr_hs) begin
      alloc_ptr  <= '0;
      retire_ptr <= '0;
    end else begin
      if (req_hs) alloc_ptr  <= alloc_ptr + l2_slot_t'(1);
      if (ret_hs) retire_ptr <= retire_ptr + l2_slot_t'(1);
    end
  end

  // Outstanding count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (req_hs & ~ret_hs) begin
      cnt_q <= cnt_q + l2_cnt_t'(1);
    end else if (ret_hs & ~req_hs) begin
      cnt_q <= cnt_q - l2_cnt_t'(1);
    end
  end

  l2_fill_done_map u_done_map (
    .clk      (clk),
    .reset    (reset),
    .set_en   (wr_hs),
    .set_idx  (wr_q.addr),
    .clr_en   (ret_hs),
    .clr_idx  (retire_ptr),
    .flush    (clr_hs),
    .rd_idx   (retire_ptr),
    .rd_bit_c (head_done)
`ifdef L2_STREAM_FILL_CHECK_EN
    ,
    .chk_idx  (i_rsp_tag),
    .chk_bit_c(chk_done)
`endif
  );

endmodule

// File: doc/l2_stream_fill.md
Name: l2_stream_fill

Overview:
- Write-side counterpart of the L2 stream read pointer.
- Tags each outgoing OpenCAPI 3.0 request with an L2 slot index.
- Accepts responses (possibly out of order) carrying a cache line and writes each line into the L2 URAM write port.
- Retires completions to the stream pointer strictly in issue order. Sits between the stream pointer's request/response interfaces and the OpenCAPI and URAM ports.

Parameters:
- l2_ncl, 256, number of L2 cache-line slots per stream; must be a power of 2.
- l2_ncl_width, $clog2(l2_ncl), slot index width.
- cl_width, 512, cache-line data width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_req_v  in  1  request from stream pointer.
- i_req_r  out  1  ready for i_req.
- o_req_v  out  1  tagged request to OpenCAPI.
- o_req_r  in  1  OpenCAPI ready.
- o_req_tag  out  l2_ncl_width  slot allocated to this request.
- i_rsp_v  in  1  OpenCAPI response valid.
- i_rsp_r  out  1  response ready.
- i_rsp_tag  in  l2_ncl_width  slot of response.
- i_rsp_d  in  cl_width  response cache line.
- o_wr_v  out  1  URAM write valid.
- o_wr_r  in  1  URAM write ready.
- o_wr_addr  out  l2_ncl_width  URAM line address.
- o_wr_d  out  cl_width  URAM write data.
- o_rsp_v  out  1  in-order completion to stream pointer.
- o_rsp_r  in  1  completion ready.
- i_clr_v  in  1  functional stream clear request.
- i_clr_r  out  1  clear accepted.
- o_cnt  out  l2_ncl_width+1  outstanding (allocated, not retired) count.

Behaviour:
- State: alloc_ptr, retire_ptr (l2_ncl_width each), cnt (l2_ncl_width+1), done bitmap (l2_ncl bits), write stage reg wr_v_q/wr_addr_q/wr_d_q.
- Reset (reset low, asynchronous): all state 0. o_wr_v=0, o_rsp_v=0, o_cnt=0, i_clr_r=0 while wr_v_q=0 and cnt=0 evaluates as 1 after release; o_req_tag=0.
- Request path (combinational, 0 latency):
  - full = (cnt == l2_ncl).
  - o_req_v = i_req_v & ~full & ~i_clr_v.
  - i_req_r = o_req_r & ~full & ~i_clr_v.
  - o_req_tag = alloc_ptr.
  - On handshake alloc_ptr++, wrapping l2_ncl-1 -> 0.
- Response path (one register stage):
  - i_rsp_r = ~wr_v_q | o_wr_r.
  - On accept, load wr_* with tag/data.
  - o_wr_v=wr_v_q, o_wr_addr=wr_addr_q, o_wr_d=wr_d_q.
  - On o_wr handshake, set done[wr_addr_q] next edge.
  - Full throughput: 1 line/cycle with o_wr_r held high.
- Retire:
  - o_rsp_v = done[retire_ptr] (registered bitmap).
  - On o_rsp handshake: clear done[retire_ptr], retire_ptr++ (wrap).
  - Latency: i_rsp accepted at edge t -> o_wr_v from t -> done set at t+1 -> o_rsp_v high after edge t+1 if the slot is the retire head.
- Counter:
  - cnt +1 on req handshake, -1 on retire handshake, unchanged when both occur in the same cycle.
  - full blocks allocation at cnt = l2_ncl.
- Set and clear of the same done bit in one cycle cannot occur legally (the set tag is outstanding; the cleared one is retiring). Set takes priority.
- Clear:
  - i_clr_r = (cnt == 0) & ~wr_v_q.
  - On handshake: alloc_ptr = retire_ptr = 0, done = 0.
  - i_clr_v high blocks new requests in the same cycle (clear wins).
  - With cnt > 0 the clear stalls until the stream drains.
- Illegal: a response whose tag is not outstanding, or a duplicate response. Behaviour is undefined unless the optional check is compiled in.

Optional Feature:
- Macro L2_STREAM_FILL_CHECK_EN.
- Defined:
  - Adds port o_err (out, 1), sticky until reset or clear handshake.
  - Set when an accepted i_rsp_tag is outside the window [retire_ptr, alloc_ptr) modulo l2_ncl, or targets a slot already done or currently in wr stage.
  - The offending response is still consumed but not written to URAM.
- Undefined: no o_err port, no window check; every response is written and sets done.

Decomposition:
- Package l2_pkg: L2_NCL, L2_NCL_WIDTH, CL_WIDTH constants; typedef l2_slot_t (logic [L2_NCL_WIDTH-1:0]); typedef cl_t (logic [CL_WIDTH-1:0]).
- One sub-module l2_fill_done_map: l2_ncl-bit bitmap with set port (idx, en), clear port (idx, en), and read port at retire_ptr. Set priority over clear; async active-low reset.

Test Plan:
- Reset release, then 3 requests with o_req_r=1 -> o_req_tag 0,1,2 on consecutive cycles, o_cnt=3, o_rsp_v=0.
- Responses with tags 2,1,0 (o_wr_r=1) -> URAM writes at addr 2,1,0 in that order. o_rsp_v rises only after tag 0 is written, then 3 consecutive retires with o_rsp_r=1; o_cnt 3->0.
- Issue 256 requests with no responses -> i_req_r=0 at o_cnt=256. Tag 0 response plus retire -> one more request accepted with tag 0 (wrap), o_cnt stays 256.
- i_clr_v with o_cnt=2 -> i_clr_r=0 until both retire, then clear handshake; next request gets tag 0.
- o_wr_r=0 for 5 cycles with responses pending -> i_rsp_r=0 after the first accept, no done set. On release, writes drain one per cycle with no data loss.
- L2_STREAM_FILL_CHECK_EN: response tag 7 with o_cnt=0 -> o_err=1 next cycle, no o_wr_v, o_err cleared by clear handshake.
